dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_starve.sv | 31 +++
 rtl/dmem_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-master data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  localparam int STARVE_CNT_W = 4;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [29:0] addr;
    logic [31:0] wd;
  } mem_req_t;

endpackage

// File: rtl/dmem_arb_starve.sv
// Counts consecutive refused M1 request cycles and flags when M1 must win.
module dmem_arb_starve
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic i_m1Req,
  input  logic i_m1Gnt,
  output logic o_forceM1
);

  localparam logic [STARVE_CNT_W-1:0] MaxCnt = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] r_starveCnt;

  // Clears whenever M1 stops asking or is served; saturates instead of wrapping.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_starveCnt <= '0;
    end else if (!i_m1Req || i_m1Gnt) begin
      r_starveCnt <= '0;
    end else if (r_starveCnt != {STARVE_CNT_W{1'b1}}) begin
      r_starveCnt <= r_starveCnt + 1'b1;
    end
  end

  assign o_forceM1 = (r_starveCnt == MaxCnt);

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority (M0) arbiter onto one dmem port, with starvation relief for M1
// and registered tracking of which master owns the read returning next cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,

  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [3:0]  M0_BE,
  input  logic [29:0] M0_ADDR,
  input  logic [31:0] M0_WD,
  output logic        M0_GNT,
  output logic        M0_RVALID,
  output logic [31:0] M0_RD,

  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [3:0]  M1_BE,
  input  logic [29:0] M1_ADDR,
  input  logic [31:0] M1_WD,
  output logic        M1_GNT,
  output logic        M1_RVALID,
  output logic [31:0] M1_RD,

  output logic        MEM_WE,
  output logic [3:0]  MEM_BE,
  output logic [29:0] MEM_ADDR,
  output logic [31:0] MEM_WD,
  input  logic [31:0] MEM_RD
);

  mem_req_t   w_m0Req;
  mem_req_t   w_m1Req;
  mem_req_t   w_selReq;
  logic       w_forceM1;
  logic       w_gntM0;
  logic       w_gntM1;
  logic       w_anyGnt;
  logic       r_pendValid;
  master_id_t r_pendOwner;

  assign w_m0Req = '{we: M0_WE, be: M0_BE, addr: M0_ADDR, wd: M0_WD};
  assign w_m1Req = '{we: M1_WE, be: M1_BE, addr: M1_ADDR, wd: M1_WD};

  dmem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .i_m1Req   (M1_REQ),
    .i_m1Gnt   (w_gntM1),
    .o_forceM1 (w_forceM1)
  );

  // Grants are gated by RESET_N so nothing reaches memory while held in reset.
  assign w_gntM1  = RESET_N & M1_REQ & (~M0_REQ | w_forceM1);
  assign w_gntM0  = RESET_N & M0_REQ & ~w_gntM1;
  assign w_anyGnt = w_gntM0 | w_gntM1;
  assign w_selReq = w_gntM1 ? w_m1Req : w_m0Req;

  assign M0_GNT   = w_gntM0;
  assign M1_GNT   = w_gntM1;
  assign MEM_WE   = w_selReq.we & w_anyGnt;
  assign MEM_BE   = RESET_N ? w_selReq.be : 4'b0000;
  assign MEM_ADDR = w_selReq.addr;
  assign MEM_WD   = w_selReq.wd;

  // Owner of the read whose data appears on MEM_RD in the following cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pendValid <= 1'b0;
      r_pendOwner <= M0;
    end else begin
      r_pendValid <= w_anyGnt & ~w_selReq.we;
      if (w_anyGnt) begin
        r_pendOwner <= w_gntM1 ? M1 : M0;
      end
    end
  end

  assign M0_RVALID = r_pendValid & (r_pendOwner == M0);
  assign M1_RVALID = r_pendValid & (r_pendOwner == M1);
  assign M0_RD     = MEM_RD;
  assign M1_RD     = MEM_RD;

endmodule
